branch_cond_resolver: RTL and testbench

BRANCH_COND_RESOLVER -- requirements
Module: branch_cond_resolver

---
 rtl/branch_cond_resolver_pkg.sv | 21 ++
 rtl/branch_fifo.sv | 45 ++++
 rtl/branch_cond_resolver.sv | 159 +++++++++++++++
 tb/tb_branch_cond_resolver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_cond_resolver_pkg.sv
// branch_cond_resolver_pkg: shared FSM encoding, B-form body field offsets and branch unit constants
package branch_cond_resolver_pkg;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_PRESENT = 2'd2
    } state_t;
    localparam int OPC_BRANCH     = 16;
    localparam int BRANCH_UNIT_ID = 6;
    localparam int BODY_W         = 28;
    // Body fields use big-endian numbering: field bit 0 sits at the body MSB.
    localparam int BO_MSB = 27;
    localparam int BO_LSB = 23;
    localparam int BI_MSB = 22;
    localparam int BI_LSB = 18;
    localparam int BD_MSB = 17;
    localparam int BD_LSB = 2;
    localparam int AA_POS = 1;
    localparam int LK_POS = 0;
    localparam int BD_W   = BD_MSB - BD_LSB + 1;
endpackage

// File: rtl/branch_fifo.sv
// branch_fifo: circular input buffer; a full buffer still takes a push when it is popped in the same cycle
module branch_fifo #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int aw = depth > 1 ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);
    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [cw-1:0]    count;
    logic             do_push;
    logic             do_pop;
    function automatic logic [aw-1:0] inc(input logic [aw-1:0] p);
        return p == aw'(depth - 1) ? '0 : p + aw'(1);
    endfunction
    assign empty   = count == '0;
    assign full    = count == cw'(depth);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + cw'(do_push) - cw'(do_pop);
        end
    end
endmodule

// File: rtl/branch_cond_resolver.sv
// branch_cond_resolver: buffers decoded B-form branches and resolves CTR/CR condition, target and LR
module branch_cond_resolver
    import branch_cond_resolver_pkg::*;
#(
    parameter int addressWidth            = 64,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 6,
    parameter int bodyWidth               = BODY_W,
    parameter int BranchUnitID            = BRANCH_UNIT_ID,
    parameter int fifoDepth               = 2
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              instructionOpcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [2:0]                         functionalUnitType_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic [instMinIdWidth-1:0]          instMinId_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instPid_i,
    input  logic [TidSize-1:0]                 instTid_i,
    input  logic [bodyWidth-1:0]               instructionBody_i,
    input  logic [31:0]                        crValue_i,
    input  logic                               ctrWrite_i,
    input  logic [addressWidth-1:0]            ctrWriteData_i,
    output logic                               stall_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               taken_o,
    output logic [addressWidth-1:0]            target_o,
    output logic                               lrWrite_o,
    output logic [addressWidth-1:0]            lr_o,
    output logic [addressWidth-1:0]            ctr_o,
    output logic [instructionCounterWidth-1:0] majId_o,
    output logic [instMinIdWidth-1:0]          minId_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic                               invalid_o
);
    localparam int entry_w = opcodeSize + 3 + addressWidth + instructionCounterWidth + instMinIdWidth
                           + 1 + PidSize + TidSize + bodyWidth;
    state_t                             state;
    state_t                             state_next;
    logic                               pop;
    logic                               resolve;
    logic                               fifo_empty;
    logic [entry_w-1:0]                 fifo_rdata;
    logic [opcodeSize-1:0]              w_opcode;
    logic [2:0]                         w_fu;
    logic [addressWidth-1:0]            w_addr;
    logic [instructionCounterWidth-1:0] w_maj;
    logic [instMinIdWidth-1:0]          w_min;
    logic                               w_is64;
    logic [PidSize-1:0]                 w_pid;
    logic [TidSize-1:0]                 w_tid;
    logic [bodyWidth-1:0]               w_body;
    logic [addressWidth-1:0]            ctr;
    logic [addressWidth-1:0]            lr;
    logic                               bo0, bo1, bo2, bo3;
    logic                               bo_hint_unused;
    logic [4:0]                         bi;
    logic [BD_W-1:0]                    bd;
    logic [addressWidth-1:0]            disp;
    logic [addressWidth-1:0]            ctr_new;
    logic                               ctr_ok;
    logic                               cond_ok;
    logic                               taken;
    logic                               entry_ok;
    logic [addressWidth-1:0]            seq_addr;
    logic [addressWidth-1:0]            target;
    function automatic logic [addressWidth-1:0] mode_mask(input logic is64, input logic [addressWidth-1:0] a);
        return is64 ? a : {{(addressWidth - 32){1'b0}}, a[31:0]};
    endfunction
    branch_fifo #(
        .width(entry_w),
        .depth(fifoDepth)
    ) u_fifo (
        .clock  (clock_i),
        .reset_n(reset_i),
        .push   (enable_i),
        .pop    (pop),
        .wdata  ({instructionOpcode_i, functionalUnitType_i, instructionAddress_i, instMajId_i,
                  instMinId_i, is64Bit_i, instPid_i, instTid_i, instructionBody_i}),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (stall_o)
    );
    always_ff @(posedge clock_i) state <= !reset_i ? S_IDLE : state_next;
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (!fifo_empty) state_next = S_RESOLVE;
            S_RESOLVE: if (!ctrWrite_i) state_next = entry_ok ? S_PRESENT : S_IDLE;
            S_PRESENT: if (ready_i) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end
    always_comb begin
        pop     = state == S_IDLE && !fifo_empty;
        resolve = state == S_RESOLVE && !ctrWrite_i;
    end
    assign bo0            = w_body[BO_MSB];
    assign bo1            = w_body[BO_MSB-1];
    assign bo2            = w_body[BO_MSB-2];
    assign bo3            = w_body[BO_MSB-3];
    // BO[4] is only a static prediction hint and has no effect on resolution.
    assign bo_hint_unused = w_body[BO_LSB];
    assign bi             = w_body[BI_MSB:BI_LSB];
    assign bd             = w_body[BD_MSB:BD_LSB];
    assign disp           = {{(addressWidth - BD_W){bd[BD_W-1]}}, bd};
    assign ctr_new        = bo2 ? ctr : ctr - addressWidth'(1);
    assign ctr_ok         = bo2 | ((w_is64 ? |ctr_new : |ctr_new[31:0]) ^ bo3);
    assign cond_ok        = bo0 | (crValue_i[5'd31 - bi] == bo1);
    assign taken          = ctr_ok & cond_ok;
    assign entry_ok       = w_opcode == opcodeSize'(OPC_BRANCH) && w_fu == 3'(BranchUnitID);
    assign seq_addr       = w_addr + addressWidth'(4);
    assign target         = mode_mask(w_is64, taken ? (w_body[AA_POS] ? disp : w_addr + disp) : seq_addr);
    assign lr_o           = lr;
    assign ctr_o          = ctr;
    always_ff @(posedge clock_i) begin
        if (pop) {w_opcode, w_fu, w_addr, w_maj, w_min, w_is64, w_pid, w_tid, w_body} <= fifo_rdata;
    end
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            ctr       <= '0;
            lr        <= '0;
            valid_o   <= 1'b0;
            taken_o   <= 1'b0;
            target_o  <= '0;
            lrWrite_o <= 1'b0;
            majId_o   <= '0;
            minId_o   <= '0;
            pid_o     <= '0;
            tid_o     <= '0;
            invalid_o <= 1'b0;
        end else begin
            if (ctrWrite_i) ctr <= ctrWriteData_i;
            else if (resolve && entry_ok) ctr <= ctr_new;
            if (resolve && entry_ok && w_body[LK_POS]) lr <= mode_mask(w_is64, seq_addr);
            invalid_o <= resolve && !entry_ok;
            if (resolve && entry_ok) begin
                valid_o   <= 1'b1;
                taken_o   <= taken;
                target_o  <= target;
                lrWrite_o <= w_body[LK_POS];
                majId_o   <= w_maj;
                minId_o   <= w_min;
                pid_o     <= w_pid;
                tid_o     <= w_tid;
            end else if (state == S_PRESENT && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_branch_cond_resolver.sv
// tb_branch_cond_resolver: directed vectors with hand-computed expectations for branch_cond_resolver
module tb_branch_cond_resolver;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [5:0]  instructionOpcode_i = '0;
    logic [63:0] instructionAddress_i = '0;
    logic [2:0]  functionalUnitType_i = '0;
    logic [63:0] instMajId_i = '0;
    logic [6:0]  instMinId_i = '0;
    logic        is64Bit_i = 1'b0;
    logic [19:0] instPid_i = '0;
    logic [15:0] instTid_i = '0;
    logic [27:0] instructionBody_i = '0;
    logic [31:0] crValue_i = '0;
    logic        ctrWrite_i = 1'b0;
    logic [63:0] ctrWriteData_i = '0;
    logic        ready_i = 1'b1;
    logic        stall_o, valid_o, taken_o, lrWrite_o, invalid_o;
    logic [63:0] target_o, lr_o, ctr_o, majId_o;
    logic [6:0]  minId_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    int checks = 0;
    int failures = 0;

    branch_cond_resolver dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .instructionOpcode_i(instructionOpcode_i), .instructionAddress_i(instructionAddress_i),
        .functionalUnitType_i(functionalUnitType_i), .instMajId_i(instMajId_i), .instMinId_i(instMinId_i),
        .is64Bit_i(is64Bit_i), .instPid_i(instPid_i), .instTid_i(instTid_i),
        .instructionBody_i(instructionBody_i), .crValue_i(crValue_i), .ctrWrite_i(ctrWrite_i),
        .ctrWriteData_i(ctrWriteData_i), .stall_o(stall_o), .valid_o(valid_o), .ready_i(ready_i),
        .taken_o(taken_o), .target_o(target_o), .lrWrite_o(lrWrite_o), .lr_o(lr_o), .ctr_o(ctr_o),
        .majId_o(majId_o), .minId_o(minId_o), .pid_o(pid_o), .tid_o(tid_o), .invalid_o(invalid_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] body(input logic [4:0] bo, input logic [4:0] bi, input logic [15:0] bd,
                                         input logic aa, input logic lk);
        return {bo, bi, bd, aa, lk};
    endfunction

    task automatic push(input logic [5:0] opc, input logic [2:0] fu, input logic [63:0] addr,
                        input logic is64, input logic [27:0] b);
        @(negedge clock_i);
        enable_i             = 1'b1;
        instructionOpcode_i  = opc;
        functionalUnitType_i = fu;
        instructionAddress_i = addr;
        is64Bit_i            = is64;
        instructionBody_i    = b;
        instMajId_i          = addr;
        instMinId_i          = addr[6:0] ^ 7'h55;
        instPid_i            = addr[19:0];
        instTid_i            = ~addr[15:0];
        @(negedge clock_i);
        enable_i = 1'b0;
    endtask

    task automatic write_ctr(input logic [63:0] v);
        @(negedge clock_i);
        ctrWrite_i     = 1'b1;
        ctrWriteData_i = v;
        @(negedge clock_i);
        ctrWrite_i = 1'b0;
    endtask

    task automatic run(input string tag, input logic [63:0] addr, input logic is64, input logic [27:0] b,
                       input logic exp_taken, input logic [63:0] exp_target);
        logic [6:0]  exp_min;
        logic [15:0] exp_tid;
        exp_min = addr[6:0] ^ 7'h55;
        exp_tid = ~addr[15:0];
        push(6'd16, 3'd6, addr, is64, b);
        check({tag, " valid_n0"}, valid_o, 0);
        @(negedge clock_i);
        check({tag, " valid_n1"}, valid_o, 0);
        @(negedge clock_i);
        check({tag, " valid_n2"}, valid_o, 1);
        check({tag, " taken"}, taken_o, exp_taken);
        check({tag, " target"}, target_o, exp_target);
        check({tag, " maj"}, majId_o, addr);
        check({tag, " min"}, minId_o, exp_min);
        check({tag, " tid"}, tid_o, exp_tid);
        @(negedge clock_i);
        check({tag, " valid_drop"}, valid_o, 0);
    endtask

    task automatic expect_result(input string tag, input logic [63:0] exp_target);
        int n = 0;
        while (!valid_o && n < 8) begin
            @(negedge clock_i);
            n++;
        end
        check({tag, " valid"}, valid_o, 1);
        check({tag, " target"}, target_o, exp_target);
        @(negedge clock_i);
        check({tag, " drop"}, valid_o, 0);
    endtask

    task automatic run_invalid(input string tag, input logic [5:0] opc, input logic [2:0] fu);
        push(opc, fu, 64'h8000, 1'b1, body(5'b10000, 5'd0, 16'h0010, 1'b0, 1'b1));
        @(negedge clock_i);
        check({tag, " early"}, invalid_o, 0);
        @(negedge clock_i);
        check({tag, " pulse"}, invalid_o, 1);
        check({tag, " no_valid"}, valid_o, 0);
        @(negedge clock_i);
        check({tag, " end"}, invalid_o, 0);
        check({tag, " ctr"}, ctr_o, 64'd3);
        check({tag, " lr"}, lr_o, 64'd0);
    endtask

    initial begin
        int extra;
        repeat (3) @(negedge clock_i);
        check("rst valid", valid_o, 0);
        check("rst stall", stall_o, 0);
        check("rst ctr", ctr_o, 0);
        check("rst lr", lr_o, 0);
        check("rst target", target_o, 0);
        check("rst invalid", invalid_o, 0);
        reset_i = 1'b1;

        run("always", 64'h1000, 1'b1, body(5'b10100, 5'd0, 16'h0040, 1'b0, 1'b1), 1'b1, 64'h1040);
        check("always lr", lr_o, 64'h1004);
        check("always lrwrite", lrWrite_o, 1);
        check("always ctr", ctr_o, 0);

        write_ctr(64'd1);
        check("ctr load", ctr_o, 64'd1);
        run("ctr1", 64'h2000, 1'b1, body(5'b10000, 5'd0, 16'h0100, 1'b0, 1'b0), 1'b0, 64'h2004);
        check("ctr1 ctr", ctr_o, 64'd0);
        check("ctr1 lrwrite", lrWrite_o, 0);
        check("ctr1 lr", lr_o, 64'h1004);
        write_ctr(64'd2);
        run("ctr2", 64'h2000, 1'b1, body(5'b10000, 5'd0, 16'h0100, 1'b0, 1'b0), 1'b1, 64'h2100);
        check("ctr2 ctr", ctr_o, 64'd1);

        crValue_i = 32'h2000_0000;
        run("cr_set", 64'h3000, 1'b1, body(5'b01100, 5'd2, 16'h0010, 1'b0, 1'b0), 1'b1, 64'h3010);
        check("cr_set ctr", ctr_o, 64'd1);
        crValue_i = 32'h0;
        run("cr_clr", 64'h3000, 1'b1, body(5'b01100, 5'd2, 16'h0010, 1'b0, 1'b0), 1'b0, 64'h3004);
        check("cr_clr ctr", ctr_o, 64'd1);

        run("abs64", 64'h4000, 1'b1, body(5'b10100, 5'd0, 16'hFFF8, 1'b1, 1'b0), 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        run("abs32", 64'h1_0000_4000, 1'b0, body(5'b10100, 5'd0, 16'hFFF8, 1'b1, 1'b1), 1'b1, 64'h0000_0000_FFFF_FFF8);
        check("abs32 lr", lr_o, 64'h4004);

        push(6'd16, 3'd6, 64'h5000, 1'b1, body(5'b10000, 5'd0, 16'h0020, 1'b0, 1'b0));
        @(negedge clock_i);
        check("ctrw valid_n1", valid_o, 0);
        ctrWrite_i     = 1'b1;
        ctrWriteData_i = 64'd5;
        @(negedge clock_i);
        ctrWrite_i = 1'b0;
        check("ctrw hold", valid_o, 0);
        check("ctrw loaded", ctr_o, 64'd5);
        @(negedge clock_i);
        check("ctrw valid", valid_o, 1);
        check("ctrw taken", taken_o, 1);
        check("ctrw target", target_o, 64'h5020);
        check("ctrw ctr", ctr_o, 64'd4);
        @(negedge clock_i);

        ready_i = 1'b0;
        push(6'd16, 3'd6, 64'h6000, 1'b1, body(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0));
        repeat (2) @(negedge clock_i);
        check("bp first valid", valid_o, 1);
        push(6'd16, 3'd6, 64'h6100, 1'b1, body(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0));
        check("bp stall1", stall_o, 0);
        push(6'd16, 3'd6, 64'h6200, 1'b1, body(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0));
        check("bp stall2", stall_o, 1);
        push(6'd16, 3'd6, 64'h6300, 1'b1, body(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0));
        check("bp stall3", stall_o, 1);
        check("bp hold valid", valid_o, 1);
        check("bp hold target", target_o, 64'h6008);
        ready_i = 1'b1;
        expect_result("bp A", 64'h6008);
        expect_result("bp B", 64'h6108);
        expect_result("bp C", 64'h6208);
        extra = 0;
        repeat (8) begin
            @(negedge clock_i);
            if (valid_o) extra++;
        end
        check("bp dropped", extra, 0);

        ready_i = 1'b0;
        push(6'd16, 3'd6, 64'h7000, 1'b1, body(5'b10100, 5'd0, 16'h0004, 1'b0, 1'b1));
        repeat (2) @(negedge clock_i);
        check("rp valid", valid_o, 1);
        push(6'd16, 3'd6, 64'h7100, 1'b1, body(5'b10100, 5'd0, 16'h0004, 1'b0, 1'b0));
        check("rp ctr before", ctr_o, 64'd4);
        reset_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b1;
        ready_i = 1'b1;
        check("rp valid", valid_o, 0);
        check("rp ctr", ctr_o, 0);
        check("rp lr", lr_o, 0);
        check("rp stall", stall_o, 0);
        check("rp target", target_o, 0);
        extra = 0;
        repeat (8) begin
            @(negedge clock_i);
            if (valid_o) extra++;
        end
        check("rp fifo empty", extra, 0);

        write_ctr(64'd3);
        run_invalid("bad opc", 6'd18, 3'd6);
        run_invalid("bad fu", 6'd16, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
